alu_issue_queue: RTL and testbench



---
 rtl/alu_issue_queue_pkg.sv | 49 ++++
 rtl/alu_issue_queue_select.sv | 29 ++
 rtl/alu_issue_queue.sv | 138 +++++++++++++
 tb/tb_alu_issue_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: decoded instruction, queue entry and
// the operand wakeup helper used on both stored and incoming entries.
package alu_issue_queue_pkg;

  localparam int IQ_DEPTH_MAX = 8;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } decoded_instr;

  typedef struct packed {
    decoded_instr instr;
    logic         rs1_pend;
    logic         rs2_pend;
  } iq_entry_t;

  // x0 is hard-wired zero, so a write to it never resolves a pending operand.
  function automatic iq_entry_t iq_wake(input iq_entry_t   e,
                                        input logic        wb_valid,
                                        input logic [4:0]  wb_idx,
                                        input logic [31:0] wb_val);
    iq_entry_t r;
    r = e;
    if (wb_valid && wb_idx != 5'd0) begin
      if (e.rs1_pend && e.instr.rs1 == wb_idx) begin
        r.instr.rs1_val = wb_val;
        r.rs1_pend      = 1'b0;
      end
      if (e.rs2_pend && e.instr.rs2 == wb_idx) begin
        r.instr.rs2_val = wb_val;
        r.rs2_pend      = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_queue_select.sv
// Lowest-index priority select: reports whether any request is set, plus the
// one-hot and binary position of the lowest one.
module alu_issue_queue_select #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top so the lowest set request is the last one to win.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found     = 1'b1;
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting issue queue in front of the ALU: in-order allocation, oldest-ready
// issue, operand capture from the writeback bus.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  bit X0_ASSERT_EN = 1'b1,
  localparam int COUNT_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  iq_entry_t          enq_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output decoded_instr       issue_data,
  input  logic               wb_valid,
  input  logic [4:0]         wb_idx,
  input  logic [31:0]        wb_val,
  output logic [COUNT_W-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]   r_valid;
  iq_entry_t          r_entry [DEPTH];
  logic [COUNT_W-1:0] r_count;

  logic [DEPTH-1:0]   w_ready;
  logic               w_sel_found;
  logic [DEPTH-1:0]   w_sel_onehot;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_fire;
  logic               w_enq;
  logic [DEPTH-1:0]   w_shift;
  logic [COUNT_W-1:0] w_wr_ptr;
  iq_entry_t          w_in_entry;
  iq_entry_t          w_woken   [DEPTH];
  iq_entry_t          w_nxt_entry [DEPTH];
  logic [DEPTH-1:0]   w_nxt_valid;
  logic [COUNT_W-1:0] w_nxt_count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_valid[i] && !r_entry[i].rs1_pend && !r_entry[i].rs2_pend;
    end
  end

  alu_issue_queue_select #(.N(DEPTH)) u_select (
    .i_req    (w_ready),
    .o_found  (w_sel_found),
    .o_onehot (w_sel_onehot),
    .o_idx    (w_sel_idx)
  );

  assign issue_valid = w_sel_found;
  assign issue_data  = r_entry[w_sel_idx].instr;
  assign w_fire      = w_sel_found && issue_ready;
  assign enq_ready   = (r_count < COUNT_W'(DEPTH)) && !flush;
  assign w_enq       = enq_valid && enq_ready;
  assign w_wr_ptr    = r_count - COUNT_W'(w_fire);
  assign count       = r_count;

  // Every slot at or above the issued one takes its upper neighbour.
  always_comb begin
    logic run;
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      run        = run | (w_fire & w_sel_onehot[i]);
      w_shift[i] = run;
    end
  end

  always_comb begin
    w_in_entry = iq_wake(enq_data, wb_valid, wb_idx, wb_val);
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = iq_wake(r_entry[i], wb_valid, wb_idx, wb_val);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_nxt_valid[i] = w_shift[i] ? r_valid[i+1] : r_valid[i];
      w_nxt_entry[i] = w_shift[i] ? w_woken[i+1] : w_woken[i];
    end
    w_nxt_valid[DEPTH-1] = w_shift[DEPTH-1] ? 1'b0 : r_valid[DEPTH-1];
    w_nxt_entry[DEPTH-1] = w_woken[DEPTH-1];

    // The write slot already accounts for the shift caused by a same-edge issue.
    if (w_enq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (COUNT_W'(i) == w_wr_ptr) begin
          w_nxt_valid[i] = 1'b1;
          w_nxt_entry[i] = w_in_entry;
        end
      end
    end

    if (flush) w_nxt_valid = '0;
  end

  always_comb begin
    w_nxt_count = r_count;
    if (flush)                 w_nxt_count = '0;
    else if (w_enq && !w_fire) w_nxt_count = r_count + 1'b1;
    else if (!w_enq && w_fire) w_nxt_count = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_count <= w_nxt_count;
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    r_entry <= w_nxt_entry;
  end

  a_depth_range: assert property (@(posedge clk) disable iff (!rst)
    (DEPTH >= 2) && (DEPTH <= IQ_DEPTH_MAX));

  a_imm_no_rs2: assert property (@(posedge clk) disable iff (!rst)
    (enq_valid && enq_data.instr.use_imm) |-> !enq_data.rs2_pend);

  if (X0_ASSERT_EN) begin : g_x0_check
    a_no_x0_pend: assert property (@(posedge clk) disable iff (!rst)
      enq_valid |-> !((enq_data.rs1_pend && enq_data.instr.rs1 == 5'd0) ||
                      (enq_data.rs2_pend && enq_data.instr.rs2 == 5'd0)));
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               enq_valid = 1'b0;
  logic               enq_ready;
  iq_entry_t          enq_data = '0;
  logic               issue_valid;
  logic               issue_ready = 1'b0;
  decoded_instr       issue_data;
  logic               wb_valid = 1'b0;
  logic [4:0]         wb_idx = '0;
  logic [31:0]        wb_val = '0;
  logic [COUNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: program-ordered list of live entries, oldest first.
  iq_entry_t mq[$];

  alu_issue_queue #(.DEPTH(DEPTH), .X0_ASSERT_EN(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_data    (enq_data),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_data  (issue_data),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .wb_val      (wb_val),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic iq_entry_t mk(input alu_op_e op, input bit use_imm, input int rd,
                                   input int rs1, input int rs2, input logic [31:0] v1,
                                   input logic [31:0] v2, input logic [31:0] imm,
                                   input bit p1, input bit p2);
    iq_entry_t e;
    e.instr.op      = op;
    e.instr.use_imm = use_imm;
    e.instr.rd      = 5'(rd);
    e.instr.rs1     = 5'(rs1);
    e.instr.rs2     = 5'(rs2);
    e.instr.rs1_val = v1;
    e.instr.rs2_val = v2;
    e.instr.imm     = imm;
    e.rs1_pend      = p1;
    e.rs2_pend      = p2;
    return e;
  endfunction

  function automatic int m_oldest_ready();
    foreach (mq[i]) if (!mq[i].rs1_pend && !mq[i].rs2_pend) return i;
    return -1;
  endfunction

  function automatic iq_entry_t m_wake(input iq_entry_t e, input bit v, input logic [4:0] idx,
                                       input logic [31:0] val);
    iq_entry_t r = e;
    if (v && idx != 0 && e.rs1_pend && e.instr.rs1 == idx) begin
      r.rs1_pend = 0; r.instr.rs1_val = val;
    end
    if (v && idx != 0 && e.rs2_pend && e.instr.rs2 == idx) begin
      r.rs2_pend = 0; r.instr.rs2_val = val;
    end
    return r;
  endfunction

  // One clock: drive after the falling edge, compare, then advance the model.
  task automatic cycle(input bit ev, input iq_entry_t e, input bit ir, input bit wv,
                       input int wi, input logic [31:0] wd, input bit fl);
    int sel;
    bit exp_rdy;
    bit fire;
    enq_valid = ev; enq_data = e; issue_ready = ir;
    wb_valid = wv; wb_idx = 5'(wi); wb_val = wd; flush = fl;
    #1;
    sel     = m_oldest_ready();
    exp_rdy = (mq.size() < DEPTH) && !fl;
    check("count", 128'(count), 128'(mq.size()));
    check("enq_ready", 128'(enq_ready), 128'(exp_rdy));
    check("issue_valid", 128'(issue_valid), 128'(sel >= 0));
    if (sel >= 0) check("issue_data", 128'(issue_data), 128'(mq[sel].instr));
    fire = (sel >= 0) && ir;
    @(posedge clk);
    if (fire) mq.delete(sel);
    foreach (mq[i]) mq[i] = m_wake(mq[i], wv, 5'(wi), wd);
    if (ev && exp_rdy) mq.push_back(m_wake(e, wv, 5'(wi), wd));
    if (fl) mq.delete();
    @(negedge clk);
  endtask

  task automatic idle(input bit ir);
    cycle(1'b0, '0, ir, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++) idle(1'b1);
    check("drained", 128'(count), 128'(0));
  endtask

  initial begin
    iq_entry_t e;
    #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_enq_ready", 128'(enq_ready), 128'(1));
    check("rst_issue_valid", 128'(issue_valid), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ADDI x1,x2,5 with rs1 already resolved
    cycle(1, mk(ALU_ADD, 1, 1, 2, 0, 32'd10, 0, 32'd5, 0, 0), 1, 0, 0, 0, 0);
    check("t1_valid", 128'(issue_valid), 128'(1));
    check("t1_imm", 128'(issue_data.imm), 128'(5));
    check("t1_rs1_val", 128'(issue_data.rs1_val), 128'(10));
    check("t1_count", 128'(count), 128'(1));
    idle(1);
    check("t1_count_after", 128'(count), 128'(0));

    // Younger ready entry overtakes an older one waiting on x1
    cycle(1, mk(ALU_ADD, 0, 3, 1, 4, 0, 32'd4, 0, 1, 0), 0, 0, 0, 0, 0);
    cycle(1, mk(ALU_ADD, 0, 5, 6, 7, 32'd6, 32'd7, 0, 0, 0), 0, 0, 0, 0, 0);
    check("t2_first_rd", 128'(issue_data.rd), 128'(5));
    cycle(0, '0, 1, 1, 1, 32'd42, 0);
    check("t2_second_valid", 128'(issue_valid), 128'(1));
    check("t2_second_rd", 128'(issue_data.rd), 128'(3));
    check("t2_second_rs1", 128'(issue_data.rs1_val), 128'(42));
    drain();

    // Fill to capacity, then release one
    for (int k = 0; k < DEPTH; k++)
      cycle(1, mk(ALU_XOR, 0, 11 + k, 1, 2, 32'(k), 32'(k + 1), 0, 0, 0), 0, 0, 0, 0, 0);
    check("t3_full_count", 128'(count), 128'(DEPTH));
    check("t3_full_ready", 128'(enq_ready), 128'(0));
    idle(1);
    check("t3_count_after", 128'(count), 128'(DEPTH - 1));
    check("t3_ready_after", 128'(enq_ready), 128'(1));
    drain();

    // Wakeup in the same cycle as the enqueue of the consumer
    cycle(1, mk(ALU_SUB, 0, 10, 9, 2, 0, 32'd2, 0, 1, 0), 0, 1, 9, 32'hDEAD, 0);
    check("t4_valid", 128'(issue_valid), 128'(1));
    check("t4_rs1_val", 128'(issue_data.rs1_val), 128'(32'hDEAD));
    drain();

    // Writes to x0 never wake; then flush with three entries resident
    cycle(1, mk(ALU_OR, 0, 8, 0, 3, 0, 0, 0, 1, 0), 1, 1, 0, 32'h1234, 0);
    for (int k = 0; k < 3; k++) cycle(0, '0, 1, 1, 0, 32'h1234, 0);
    check("t5_x0_no_wake", 128'(issue_valid), 128'(0));
    cycle(0, '0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      cycle(1, mk(ALU_AND, 0, 20 + k, 4, 5, 32'(k), 0, 0, 0, 0), 0, 0, 0, 0, 0);
    check("t5_pre_flush_count", 128'(count), 128'(3));
    cycle(0, '0, 0, 0, 0, 0, 1);
    check("t5_flush_count", 128'(count), 128'(0));
    check("t5_flush_valid", 128'(issue_valid), 128'(0));
    idle(1);
    idle(1);

    // Reset in the middle of operation
    cycle(1, mk(ALU_SLL, 0, 21, 20, 2, 0, 32'd1, 0, 1, 0), 0, 0, 0, 0, 0);
    cycle(1, mk(ALU_SRL, 0, 22, 20, 2, 0, 32'd1, 0, 1, 0), 0, 0, 0, 0, 0);
    enq_valid = 0; issue_ready = 1; wb_valid = 0; flush = 0;
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", 128'(issue_valid), 128'(0));
    check("t6_rst_count", 128'(count), 128'(0));
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle(0, '0, 1, 1, 20, 32'h55, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit imm_sel;
      imm_sel = $urandom_range(0, 1) == 1;
      e = mk(alu_op_e'($urandom_range(0, 9)), imm_sel, $urandom_range(1, 31),
             $urandom_range(1, 7), $urandom_range(1, 7), $urandom, $urandom, $urandom,
             $urandom_range(0, 2) == 0, !imm_sel && $urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 4) < 3, e, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
